// File: rtl/led_step_sequencer.sv
// rtl/led_step_sequencer.sv - stepped LED pattern generator with register slave and PIO write master
module led_step_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [31:0] period_q, period_d;
  logic [7:0]  pattern_q, pattern_d;
  logic        dir_q, dir_d;
  logic [31:0] cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic        irq_q, irq_d;
  logic        pio_q, pio_d;
  logic [7:0]  pio_data_q, pio_data_d;

  logic        wr;
  logic        wr_ctrl, wr_period, wr_pattern, wr_status;
  logic [31:0] max_cnt;
  logic        tick;
  logic [7:0]  step_pat;
  logic        step_dir;
  logic        step_wrap;

  assign wr         = chipselect & ~write_n;
  assign wr_ctrl    = wr && (address == 2'd0);
  assign wr_period  = wr && (address == 2'd1);
  assign wr_pattern = wr && (address == 2'd2);
  assign wr_status  = wr && (address == 2'd3);

  // A zero period behaves as one; >= lets a shortened period fire on the next cycle
  assign max_cnt = (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;
  assign tick    = (cnt_q >= max_cnt);

  assign irq          = irq_q;
  assign m_address    = 2'b00;
  assign m_chipselect = pio_q;
  assign m_write_n    = ~pio_q;
  assign m_writedata  = {24'd0, pio_data_q};

  // Register readback, unused bits zero
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {27'd0, ctrl_q};
      2'd1:    readdata = period_q;
      2'd2:    readdata = {24'd0, pattern_q};
      default: readdata = {15'd0, dir_q, pattern_q, 6'd0, wrap_q, (state_q != S_IDLE)};
    endcase
  end

  // One step of the selected mode, plus the wrap event it produces
  always_comb begin
    step_pat  = pattern_q;
    step_dir  = dir_q;
    step_wrap = 1'b0;
    case (ctrl_q[2:1])
      2'b00: begin
        step_pat  = {pattern_q[6:0], pattern_q[7]};
        step_wrap = pattern_q[7];
      end
      2'b01: begin
        step_pat  = {pattern_q[0], pattern_q[7:1]};
        step_wrap = pattern_q[0];
      end
      2'b10: begin
        if (!dir_q) begin
          if (pattern_q[7]) begin
            step_dir  = 1'b1;
            step_pat  = pattern_q >> 1;
            step_wrap = 1'b1;
          end else begin
            step_pat = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            step_dir  = 1'b0;
            step_pat  = pattern_q << 1;
            step_wrap = 1'b1;
          end else begin
            step_pat = pattern_q >> 1;
          end
        end
      end
      default: begin
        step_pat  = pattern_q + 8'd1;
        step_wrap = &pattern_q;
      end
    endcase
  end

  // Next state, register writes and PIO write requests
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    period_d   = period_q;
    pattern_d  = pattern_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    wrap_d     = wrap_q;
    pio_d      = 1'b0;
    pio_data_d = pio_data_q;

    if (wr_ctrl)                   ctrl_d   = writedata[4:0];
    if (wr_period)                 period_d = writedata;
    if (wr_status && writedata[1]) wrap_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_pattern) pattern_d = writedata[7:0];
        if (wr_ctrl && writedata[0]) begin
          state_d    = S_RUN;
          cnt_d      = 32'd0;
          dir_d      = 1'b0;
          pio_d      = 1'b1;
          pio_data_d = pattern_q;
        end
      end
      S_RUN: begin
        if (wr_ctrl && !writedata[0]) begin
          // A step landing on the stop cycle is dropped
          state_d = S_STOP;
        end else if (wr_pattern) begin
          pattern_d  = writedata[7:0];
          cnt_d      = 32'd0;
          pio_d      = 1'b1;
          pio_data_d = writedata[7:0];
        end else if (tick) begin
          pattern_d  = step_pat;
          dir_d      = step_dir;
          cnt_d      = 32'd0;
          pio_d      = 1'b1;
          pio_data_d = step_pat;
          // Set after the W1C so a coincident wrap survives the clear
          if (step_wrap) wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (wr_pattern) pattern_d = writedata[7:0];
        if (ctrl_q[4]) begin
          pio_d      = 1'b1;
          pio_data_d = 8'd0;
        end
      end
    endcase

    irq_d = wrap_d & ctrl_d[3];
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= 5'd0;
      period_q   <= 32'd0;
      pattern_q  <= 8'd0;
      dir_q      <= 1'b0;
      cnt_q      <= 32'd0;
      wrap_q     <= 1'b0;
      irq_q      <= 1'b0;
      pio_q      <= 1'b0;
      pio_data_q <= 8'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      pattern_q  <= pattern_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      irq_q      <= irq_d;
      pio_q      <= pio_d;
      pio_data_q <= pio_data_d;
    end
  end

endmodule

// File: doc/led_step_sequencer.md
LED_STEP_SEQUENCER -- requirements
Module: led_step_sequencer

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  slave register select
- chipselect  in  1  slave select
- write_n  in  1  slave write strobe, active-low
- writedata  in  32  slave write data
- readdata  out  32  slave read data, combinational, zero wait states
- irq  out  1  wrap interrupt, level, registered
- m_address  out  2  master address to LED PIO, constant 0
- m_chipselect  out  1  master select to LED PIO, registered
- m_write_n  out  1  master write strobe, active-low, registered
- m_writedata  out  32  master write data, {24'b0, pattern}, registered

REQ-002 SHALL use one clock (clk) with asynchronous active-low reset (reset_n); no other clock or reset.

Function
REQ-003 SHALL decode slave writes as chipselect & ~write_n; reads return the addressed register, all unused bits 0.
REQ-004 SHALL implement the register map:
- 0 CTRL: bit0 run, bits2:1 mode (00 rotl, 01 rotr, 10 bounce, 11 count), bit3 irq_en, bit4 clr_on_stop
- 1 PERIOD: 32-bit clk cycles per step; 0 treated as 1
- 2 PATTERN: bits7:0 seed; write loads pattern
- 3 STATUS: bit0 busy (state != IDLE), bit1 wrap (write 1 to clear), bits15:8 current pattern, bit16 dir (bounce, 1 = right)
REQ-005 SHALL have FSM states IDLE, RUN, STOP; IDLE->RUN when CTRL.run written 1; RUN->STOP when CTRL.run written 0; STOP->IDLE after one cycle.
REQ-006 SHALL, on entering RUN, clear tick counter, clear dir, and issue one PIO write of the current pattern on the following cycle.
REQ-007 SHALL, in RUN, count cycles; when counter = max(PERIOD,1)-1, counter returns to 0, pattern advances one step, and a PIO write of the new pattern is issued the next cycle.
REQ-008 SHALL make each PIO write exactly one cycle: m_chipselect=1, m_write_n=0; otherwise m_chipselect=0, m_write_n=1.
REQ-009 SHALL step: rotl {p[6:0],p[7]}; rotr {p[0],p[7:1]}; count p+1 mod 256; bounce: dir=0 shift left unless p[7]=1 (then dir<=1, shift right); dir=1 shift right unless p[0]=1 (then dir<=0, shift left); p=0 stays 0.
REQ-010 SHALL set STATUS.wrap on step when: rotl old p[7]=1; rotr old p[0]=1; count old p=0xFF; bounce dir reverses.
REQ-011 SHALL drive irq = STATUS.wrap & CTRL.irq_en.
REQ-012 SHALL, in STOP, issue a PIO write of 0x00 if clr_on_stop=1, else no write; pattern register retained.
REQ-013 SHALL, on PATTERN write in RUN, load seed, restart counter at 0, and issue a PIO write of the seed next cycle; a coincident tick step is discarded.
REQ-014 SHALL, on PATTERN write in IDLE, load seed without any PIO write.
REQ-015 SHALL apply a PERIOD write immediately; if counter already >= new max(PERIOD,1)-1, step occurs on the next cycle.
REQ-016 SHALL, on simultaneous wrap set and STATUS W1C clear, keep wrap set.
REQ-017 SHALL accept mode change in RUN; it takes effect on the next step, dir unchanged.

Reset
REQ-018 SHALL on reset_n=0 immediately force: state IDLE, CTRL 0, PERIOD 0, pattern 0x00, dir 0, counter 0, wrap 0, irq 0, m_chipselect 0, m_write_n 1, m_writedata 0, m_address 0.
REQ-019 SHALL abort any pending PIO write when reset asserts mid-operation; no write issued after release until run is set.

Verification
REQ-020 PERIOD=3, PATTERN=0x01, CTRL=0x01 -> PIO writes 0x01, then 0x02, 0x04, 0x08 exactly 3 cycles apart, each strobe 1 cycle.
REQ-021 mode count, PATTERN=0xFE, irq_en=1, PERIOD=1 -> writes 0xFF, 0x00 on consecutive cycles; STATUS.wrap=1, irq=1; write STATUS 0x2 -> irq 0.
REQ-022 mode bounce, PATTERN=0x40, PERIOD=1 -> 0x80, 0x40, 0x20; dir=1 after 0x80 step; wrap set once.
REQ-023 run with clr_on_stop=1, write CTRL=0x10 -> one PIO write 0x00, busy=0 after 2 cycles; repeat with clr_on_stop=0 -> no write.
REQ-024 PATTERN write same cycle as tick in RUN -> only seed written, next step max(PERIOD,1) cycles later.
REQ-025 assert reset_n mid-RUN, PERIOD=0 -> all outputs at reset values same cycle; no strobes until CTRL.run rewritten.
